// File: rtl/fa_marker_accumulator.sv
// ---------------------------------------------------------------------------
// fa_marker_accumulator
//
// Purpose: consumes the EVR fast-acquisition marker in the evrClk domain. It
// sums a signed sample stream over each interval between marker rising edges.
// At every boundary it emits one record (sum, count, saturated) together with
// a single-cycle sumValid strobe.
//
// Optional feature: define FA_ACCUM_TIMEOUT_EN to add a marker watchdog. The
// watchdog drops back to IDLE and raises the sticky lostMarker flag after
// TIMEOUT clocks in ACCUM with no marker edge. Without the macro, lostMarker
// is tied to 0 and ACCUM persists indefinitely.
//
// Ports:
//   evrClk       in   sole clock
//   evrReset     in   synchronous active-high reset
//   marker       in   FA marker (may be stretched; only the rising edge is used)
//   sampleValid  in   sampleData is valid this cycle
//   sampleData   in   signed sample, DATA_WIDTH bits
//   overrunClear in   clears the sticky overrun flag (and lostMarker)
//   sumValid     out  one-cycle strobe marking a new record
//   sum          out  signed sum of the completed interval
//   count        out  samples accepted in the completed interval
//   saturated    out  completed interval hit MAX_COUNT
//   overrun      out  sticky: a sample was dropped
//   synced       out  high while in ACCUM
//   lostMarker   out  sticky watchdog flag
// ---------------------------------------------------------------------------
module fa_marker_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_COUNT   = 4096,
    parameter int COUNT_WIDTH = $clog2(MAX_COUNT) + 1,
    parameter int SUM_WIDTH   = DATA_WIDTH + COUNT_WIDTH,
    parameter int TIMEOUT     = 2 ** 24
) (
    input  logic                          evrClk,
    input  logic                          evrReset,
    input  logic                          marker,
    input  logic                          sampleValid,
    input  logic signed [DATA_WIDTH-1:0]  sampleData,
    input  logic                          overrunClear,
    output logic                          sumValid,
    output logic signed [SUM_WIDTH-1:0]   sum,
    output logic [COUNT_WIDTH-1:0]        count,
    output logic                          saturated,
    output logic                          overrun,
    output logic                          synced,
    output logic                          lostMarker
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] MaxCnt   = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    state_t                        state_q, state_d;
    logic                          markerDly_q;
    logic signed [SUM_WIDTH-1:0]   accSum_q, accSum_d;
    logic [COUNT_WIDTH-1:0]        accCount_q, accCount_d;
    logic                          accSat_q, accSat_d;
    logic                          sumValid_q, sumValid_d;
    logic signed [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [COUNT_WIDTH-1:0]        count_q, count_d;
    logic                          saturated_q, saturated_d;
    logic                          overrun_q, overrun_d;

    logic                          markerEdge;
    logic signed [SUM_WIDTH-1:0]   sampleExt;

    assign markerEdge = marker & ~markerDly_q;
    assign sampleExt  = {{(SUM_WIDTH - DATA_WIDTH){sampleData[DATA_WIDTH-1]}}, sampleData};

`ifdef FA_ACCUM_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [WD_WIDTH-1:0] WdLast = WD_WIDTH'(TIMEOUT - 1);

    logic [WD_WIDTH-1:0] wd_q, wd_d;
    logic                lostMarker_q, lostMarker_d;
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT == 0);
`endif

    // Next-state logic: edge handling, interval restart, sample accumulation
    // with the MAX_COUNT limit, and the sticky flags. A boundary cycle both
    // closes the old interval and starts the new one with its own sample.
    always_comb begin
        state_d     = state_q;
        accSum_d    = accSum_q;
        accCount_d  = accCount_q;
        accSat_d    = accSat_q;
        sumValid_d  = 1'b0;
        sum_d       = sum_q;
        count_d     = count_q;
        saturated_d = saturated_q;
        overrun_d   = overrun_q & ~overrunClear;
`ifdef FA_ACCUM_TIMEOUT_EN
        wd_d         = '0;
        lostMarker_d = lostMarker_q & ~overrunClear;
`endif

        case (state_q)
            IDLE: begin
                accSum_d   = '0;
                accCount_d = '0;
                accSat_d   = 1'b0;
                if (markerEdge) begin
                    state_d = ACCUM;
                    if (sampleValid) begin
                        accSum_d   = sampleExt;
                        accCount_d = CountOne;
                    end
                end
            end

            ACCUM: begin
                if (markerEdge) begin
                    sumValid_d  = 1'b1;
                    sum_d       = accSum_q;
                    count_d     = accCount_q;
                    saturated_d = accSat_q;
                    accSat_d    = 1'b0;
                    accSum_d    = '0;
                    accCount_d  = '0;
                    if (sampleValid) begin
                        accSum_d   = sampleExt;
                        accCount_d = CountOne;
                    end
                end else begin
                    if (sampleValid) begin
                        if (accCount_q < MaxCnt) begin
                            accSum_d   = accSum_q + sampleExt;
                            accCount_d = accCount_q + CountOne;
                        end else begin
                            accSat_d  = 1'b1;
                            overrun_d = 1'b1;
                        end
                    end
`ifdef FA_ACCUM_TIMEOUT_EN
                    // Watchdog expiry wins over any sample in the same cycle:
                    // the partial interval is thrown away.
                    if (wd_q == WdLast) begin
                        state_d      = IDLE;
                        accSum_d     = '0;
                        accCount_d   = '0;
                        accSat_d     = 1'b0;
                        lostMarker_d = 1'b1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all cleared by the synchronous reset.
    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            state_q     <= IDLE;
            markerDly_q <= 1'b0;
            accSum_q    <= '0;
            accCount_q  <= '0;
            accSat_q    <= 1'b0;
            sumValid_q  <= 1'b0;
            sum_q       <= '0;
            count_q     <= '0;
            saturated_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            markerDly_q <= marker;
            accSum_q    <= accSum_d;
            accCount_q  <= accCount_d;
            accSat_q    <= accSat_d;
            sumValid_q  <= sumValid_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            saturated_q <= saturated_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef FA_ACCUM_TIMEOUT_EN
    // Watchdog counter and its sticky flag.
    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            wd_q         <= '0;
            lostMarker_q <= 1'b0;
        end else begin
            wd_q         <= wd_d;
            lostMarker_q <= lostMarker_d;
        end
    end

    assign lostMarker = lostMarker_q;
`else
    assign lostMarker = 1'b0;
`endif

    assign sumValid  = sumValid_q;
    assign sum       = sum_q;
    assign count     = count_q;
    assign saturated = saturated_q;
    assign overrun   = overrun_q;
    assign synced    = (state_q == ACCUM);

endmodule

// File: tb/tb_fa_marker_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fa_marker_accumulator
//
// Directed bench for fa_marker_accumulator. Two instances share the stimulus:
// dutA uses the default MAX_COUNT and dutB uses MAX_COUNT=8 for the
// saturation case. Both use TIMEOUT=100 so that the watchdog case is short
// when FA_ACCUM_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_fa_marker_accumulator;

    logic               evrClk = 1'b0;
    logic               evrReset = 1'b0;
    logic               marker = 1'b0;
    logic               sampleValid = 1'b0;
    logic signed [15:0] sampleData = '0;
    logic               overrunClear = 1'b0;

    logic               sumValidA, saturatedA, overrunA, syncedA, lostMarkerA;
    logic signed [28:0] sumA;
    logic [12:0]        countA;

    logic               sumValidB, saturatedB, overrunB, syncedB, lostMarkerB;
    logic signed [19:0] sumB;
    logic [3:0]         countB;

    int compared = 0;
    int mismatched = 0;
    int recA = 0;
    int recB = 0;

    fa_marker_accumulator #(.TIMEOUT(100)) dutA (
        .evrClk       (evrClk),
        .evrReset     (evrReset),
        .marker       (marker),
        .sampleValid  (sampleValid),
        .sampleData   (sampleData),
        .overrunClear (overrunClear),
        .sumValid     (sumValidA),
        .sum          (sumA),
        .count        (countA),
        .saturated    (saturatedA),
        .overrun      (overrunA),
        .synced       (syncedA),
        .lostMarker   (lostMarkerA)
    );

    fa_marker_accumulator #(.MAX_COUNT(8), .TIMEOUT(100)) dutB (
        .evrClk       (evrClk),
        .evrReset     (evrReset),
        .marker       (marker),
        .sampleValid  (sampleValid),
        .sampleData   (sampleData),
        .overrunClear (overrunClear),
        .sumValid     (sumValidB),
        .sum          (sumB),
        .count        (countB),
        .saturated    (saturatedB),
        .overrun      (overrunB),
        .synced       (syncedB),
        .lostMarker   (lostMarkerB)
    );

    always #5 evrClk = ~evrClk;

    // Drive one cycle of stimulus, wait for the clock edge, settle, and count
    // the record strobes seen in the new cycle.
    task automatic applyStimulus(input logic mk, input logic sv, input logic signed [15:0] sd);
        marker      = mk;
        sampleValid = sv;
        sampleData  = sd;
        @(posedge evrClk);
        #1;
        if (sumValidA) recA++;
        if (sumValidB) recB++;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        evrReset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'sd0);
        applyStimulus(1'b0, 1'b0, 16'sd0);
        evrReset = 1'b0;
        recA = 0;
        recB = 0;
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_sumValid", longint'(sumValidA), 0);
        checkOutput("rst_sum", longint'(sumA), 0);
        checkOutput("rst_count", longint'(countA), 0);
        checkOutput("rst_synced", longint'(syncedA), 0);
        checkOutput("rst_overrun", longint'(overrunA), 0);
        checkOutput("rst_lostMarker", longint'(lostMarkerA), 0);

        // First interval: 10 samples of +100
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t1_synced", longint'(syncedA), 1);
        checkOutput("t1_noFirstRecord", longint'(recA), 0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 16'sd100);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t1_sumValid", longint'(sumValidA), 1);
        checkOutput("t1_sum", longint'(sumA), 1000);
        checkOutput("t1_count", longint'(countA), 10);
        checkOutput("t1_saturated", longint'(saturatedA), 0);
        applyStimulus(1'b0, 1'b0, 16'sd0);
        checkOutput("t1_strobeDrops", longint'(sumValidA), 0);
        checkOutput("t1_sumHeld", longint'(sumA), 1000);
        checkOutput("t1_records", longint'(recA), 1);

        // Boundary sample belongs to the next interval
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'sd7);
        applyStimulus(1'b1, 1'b1, -16'sd5);
        checkOutput("t2_sum", longint'(sumA), 21);
        checkOutput("t2_count", longint'(countA), 3);
        applyStimulus(1'b0, 1'b1, 16'sd10);
        applyStimulus(1'b0, 1'b1, 16'sd10);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t2_nextSum", longint'(sumA), 15);
        checkOutput("t2_nextCount", longint'(countA), 3);
        applyStimulus(1'b0, 1'b0, 16'sd0);

        // Saturation on the MAX_COUNT=8 instance
        doReset();
        applyStimulus(1'b1, 1'b0, 16'sd0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 16'sd1);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t3_sumValid", longint'(sumValidB), 1);
        checkOutput("t3_sum", longint'(sumB), 8);
        checkOutput("t3_count", longint'(countB), 8);
        checkOutput("t3_saturated", longint'(saturatedB), 1);
        checkOutput("t3_overrun", longint'(overrunB), 1);
        checkOutput("t3_noOverrunWide", longint'(overrunA), 0);
        checkOutput("t3_wideCount", longint'(countA), 12);
        overrunClear = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'sd0);
        overrunClear = 1'b0;
        checkOutput("t3_overrunCleared", longint'(overrunB), 0);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t3_satCleared", longint'(saturatedB), 0);
        checkOutput("t3_emptyCount", longint'(countB), 0);
        applyStimulus(1'b0, 1'b0, 16'sd0);

        // Stretched marker gives one record; close-spaced edges give empty records
        doReset();
        applyStimulus(1'b1, 1'b0, 16'sd0);
        applyStimulus(1'b0, 1'b1, 16'sd3);
        applyStimulus(1'b0, 1'b1, 16'sd3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 16'sd4);
        checkOutput("t4_oneRecord", longint'(recA), 1);
        checkOutput("t4_sum", longint'(sumA), 6);
        checkOutput("t4_count", longint'(countA), 2);
        applyStimulus(1'b0, 1'b0, 16'sd0);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t4_stretchSum", longint'(sumA), 20);
        checkOutput("t4_stretchCount", longint'(countA), 5);
        applyStimulus(1'b0, 1'b0, 16'sd0);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t4_b2bSum", longint'(sumA), 0);
        checkOutput("t4_b2bCount", longint'(countA), 0);
        applyStimulus(1'b0, 1'b0, 16'sd0);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t4_b2bValid", longint'(sumValidA), 1);
        checkOutput("t4_b2bCount2", longint'(countA), 0);
        checkOutput("t4_records", longint'(recA), 4);
        applyStimulus(1'b0, 1'b0, 16'sd0);

        // Mid-interval reset discards the partial interval
        doReset();
        applyStimulus(1'b1, 1'b0, 16'sd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'sd9);
        evrReset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'sd0);
        evrReset = 1'b0;
        checkOutput("t5_sumValid", longint'(sumValidA), 0);
        checkOutput("t5_synced", longint'(syncedA), 0);
        applyStimulus(1'b0, 1'b1, 16'sd50);
        checkOutput("t5_idleSynced", longint'(syncedA), 0);
        applyStimulus(1'b1, 1'b1, 16'sd1);
        checkOutput("t5_resynced", longint'(syncedA), 1);
        checkOutput("t5_noRecordFirstEdge", longint'(sumValidA), 0);
        applyStimulus(1'b0, 1'b1, 16'sd2);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t5_sum", longint'(sumA), 3);
        checkOutput("t5_count", longint'(countA), 2);
        checkOutput("t5_records", longint'(recA), 1);
        applyStimulus(1'b0, 1'b0, 16'sd0);

`ifdef FA_ACCUM_TIMEOUT_EN
        // Watchdog expiry after 100 clocks without a marker edge
        doReset();
        applyStimulus(1'b1, 1'b0, 16'sd0);
        for (int i = 0; i < 99; i++) applyStimulus(1'b0, 1'b1, 16'sd1);
        checkOutput("t6_stillSynced", longint'(syncedA), 1);
        applyStimulus(1'b0, 1'b1, 16'sd1);
        checkOutput("t6_synced", longint'(syncedA), 0);
        checkOutput("t6_lostMarker", longint'(lostMarkerA), 1);
        checkOutput("t6_records", longint'(recA), 0);
        applyStimulus(1'b1, 1'b0, 16'sd0);
        checkOutput("t6_reentered", longint'(syncedA), 1);
        checkOutput("t6_noRecordOnReentry", longint'(sumValidA), 0);
        checkOutput("t6_lostSticky", longint'(lostMarkerA), 1);
`else
        // Without the watchdog ACCUM persists and lostMarker stays 0
        doReset();
        applyStimulus(1'b1, 1'b0, 16'sd0);
        for (int i = 0; i < 150; i++) applyStimulus(1'b0, 1'b0, 16'sd0);
        checkOutput("t6_stillSynced", longint'(syncedA), 1);
        checkOutput("t6_lostMarker", longint'(lostMarkerA), 0);
        checkOutput("t6_records", longint'(recA), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fa_marker_accumulator.md
# fa_marker_accumulator

Downstream consumer of the EVR fast-acquisition marker in the `evrClk` domain. It accumulates a signed sample stream over each interval between successive marker rising edges. At each boundary it emits one record: sum, sample count and status, with a single-cycle valid. The records feed the FA/SA data path that the acquisition-sync block paces.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: width of the signed input sample.
- `MAX_COUNT`, default 4096: maximum number of samples accepted per interval.
- `COUNT_WIDTH`, default `$clog2(MAX_COUNT)+1`: width of the count output.
- `SUM_WIDTH`, default `DATA_WIDTH+COUNT_WIDTH`: width of the signed sum.
- `TIMEOUT`, default 2^24: watchdog limit in clocks. Used only with `FA_ACCUM_TIMEOUT_EN`.

Ports:
- `evrClk`, in, 1: sole clock.
- `evrReset`, in, 1: synchronous, active-high reset.
- `marker`, in, 1: FA marker. May be stretched; only its rising edge is used.
- `sampleValid`, in, 1: `sampleData` is valid this cycle.
- `sampleData`, in, `DATA_WIDTH`: signed sample.
- `overrunClear`, in, 1: clears the sticky `overrun` flag.
- `sumValid`, out, 1: one-cycle strobe marking a new record.
- `sum`, out, `SUM_WIDTH`: signed sum for the completed interval.
- `count`, out, `COUNT_WIDTH`: number of samples accepted in the completed interval.
- `saturated`, out, 1: the completed interval hit `MAX_COUNT`. Qualified by `sumValid`.
- `overrun`, out, 1: sticky; set when any sample was dropped.
- `synced`, out, 1: high while in state ACCUM.
- `lostMarker`, out, 1: sticky watchdog flag. Tied to 0 when the feature is compiled out.

## Operation
- **Edge detect:** `markerEdge = marker & ~marker_d`. `marker_d` is a register with reset value 0.
- **State IDLE** (entered on reset):
  - Samples are discarded and the accumulator is held at 0.
  - On `markerEdge`, go to ACCUM with an empty accumulator.
  - If `sampleValid` is high in that same cycle, that sample is accumulated (count 1).
  - No record is emitted for this first edge.
- **State ACCUM**, on each `sampleValid` without `markerEdge`:
  - If `acc_count < MAX_COUNT`: `acc_sum += sign-extended sampleData` and `acc_count += 1`.
  - Otherwise drop the sample, set `acc_sat` and set `overrun`.
- **State ACCUM**, on `markerEdge`:
  - Copy `acc_sum`, `acc_count` and `acc_sat` to `sum`, `count` and `saturated`.
  - Pulse `sumValid`.
  - Restart the accumulator. A sample valid in the boundary cycle belongs to the new interval: sum = sample, count = 1.
- **Zero-sample interval:** emits `sum`=0, `count`=0.
- **Arithmetic:** no wrap is possible. `SUM_WIDTH` covers `MAX_COUNT` full-scale samples.
- **`overrunClear`:** clears `overrun` in the next cycle. If a drop occurs in the same cycle, the set wins.
- **Reset values:** all outputs are 0. State is IDLE. Accumulators are 0.

## Timing
- A `markerEdge` at rising clock edge N produces `sumValid`=1 during cycle N+1 only. `sum`, `count` and `saturated` update at the same edge.
- Output registers hold their value until the next record.
- Markers one clock apart: each rising edge emits a record. The second record has `count` 0 or 1.
- A stretched `marker` (high for k cycles) emits exactly one record.
- `evrReset` asserted mid-interval:
  - The partial interval is discarded and no record is emitted.
  - `sumValid` is 0 in the cycle after reset.

## Configuration
- `FA_ACCUM_TIMEOUT_EN` defined:
  - A watchdog counts clocks since the last `markerEdge` while in ACCUM.
  - When the count reaches `TIMEOUT` without an edge: go to IDLE, set sticky `lostMarker`, discard the partial interval.
  - `lostMarker` clears only on `evrReset` or `overrunClear`.
- `FA_ACCUM_TIMEOUT_EN` undefined:
  - No watchdog logic.
  - `lostMarker` is constant 0.
  - ACCUM persists indefinitely without markers.

## Test plan
- **First interval:** reset, then marker edge, then 10 samples of +100, then marker edge. Required: exactly one `sumValid`, `sum`=1000, `count`=10, `saturated`=0. No record for the first edge.
- **Boundary sample:** a sample of −5 coincides with the second marker edge, after 3 samples of 7. Required: record `sum`=21, `count`=3. Next record includes −5 with count starting at 1.
- **Saturation:** `MAX_COUNT`=8, feed 12 samples of +1 in one interval. Required: `sum`=8, `count`=8, `saturated`=1, `overrun`=1. `overrunClear` drops `overrun` to 0 one cycle later.
- **Stretched and back-to-back markers:** marker held high for 5 cycles gives 1 record. Marker edges 2 cycles apart with no samples give records with `count`=0, `sum`=0.
- **Mid-interval reset:** accumulate 4 samples, assert `evrReset` for 1 cycle, then apply 2 marker edges. Required: only the post-reset interval is reported; `synced`=0 until the first post-reset edge.
- **Watchdog** (`FA_ACCUM_TIMEOUT_EN`, `TIMEOUT`=100): no marker for 100 clocks in ACCUM. Required: `synced` falls to 0, `lostMarker`=1, no record. The next edge re-enters ACCUM.
